// File: rtl/sipo_rx.sv
// sipo_rx: serial-in, parallel-out word receiver for the PISO link test path.
// Reassembles an MSB-first serial stream into WIDTH-bit words using a FRAME
// marker on the first bit, and presents each word with a level-valid/ack
// handshake plus framing-error pulse and sticky overflow reporting.
// Optional feature macro: SIPO_RX_PARITY_EN adds a trailing even-parity bit
// per frame (PAR state) and drives PERR; without it PERR is tied to 0.
module sipo_rx #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SIN,
   input  logic             SIN_EN,
   input  logic             FRAME,
   input  logic             POUT_ACK,
   output logic [WIDTH-1:0] POUT,
   output logic             POUT_VALID,
   output logic             BUSY,
   output logic             ERR,
   output logic             OVF,
   output logic             PERR
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_RX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_d;
   logic [WIDTH-1:0] shreg, shreg_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [WIDTH-1:0] pout_d;
   logic             valid_d, err_d, ovf_d;
   logic             complete;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] shifted, started;
`ifdef SIPO_RX_PARITY_EN
   logic             perr_q, perr_d, perr_word;
`endif

   assign shifted = {shreg[WIDTH-2:0], SIN};
   assign started = {{(WIDTH-1){1'b0}}, SIN};

   // Next-state, datapath and handshake decode for one accepted bit.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d  = state;
      shreg_d  = shreg;
      cnt_d    = cnt;
      pout_d   = POUT;
      valid_d  = POUT_VALID;
      err_d    = 1'b0;
      ovf_d    = OVF;
      complete = 1'b0;
      word     = shreg;
`ifdef SIPO_RX_PARITY_EN
      perr_d    = perr_q;
      perr_word = 1'b0;
`endif

      if (SIN_EN) begin
         if (FRAME) begin
            // A frame marker always starts a new word; mid-word it is a resync.
            err_d   = (state != IDLE);
            shreg_d = started;
            cnt_d   = CW'(1);
            state_d = SHIFT;
         end else begin
            case (state)
               IDLE: ;  // stray bit without a frame marker is dropped
               SHIFT: begin
                  shreg_d = shifted;
                  cnt_d   = cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_RX_PARITY_EN
                     state_d = PAR;
`else
                     complete = 1'b1;
                     word     = shifted;
                     cnt_d    = '0;
                     state_d  = IDLE;
`endif
                  end
               end
`ifdef SIPO_RX_PARITY_EN
               PAR: begin
                  complete  = 1'b1;
                  word      = shreg;
                  perr_word = (^shreg) ^ SIN;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end
`endif
               default: state_d = IDLE;
            endcase
         end
      end

      if (complete) begin
         // An unacknowledged word being overwritten is an overflow.
         if (POUT_VALID && !POUT_ACK) ovf_d = 1'b1;
         pout_d  = word;
         valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
         perr_d  = perr_word;
`endif
      end else if (POUT_ACK && POUT_VALID) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!RST_N) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         POUT       <= '0;
         POUT_VALID <= 1'b0;
         ERR        <= 1'b0;
         OVF        <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         state      <= state_d;
         shreg      <= shreg_d;
         cnt        <= cnt_d;
         POUT       <= pout_d;
         POUT_VALID <= valid_d;
         ERR        <= err_d;
         OVF        <= ovf_d;
`ifdef SIPO_RX_PARITY_EN
         perr_q     <= perr_d;
`endif
      end
   end

   assign BUSY = (state != IDLE);

`ifdef SIPO_RX_PARITY_EN
   assign PERR = perr_q;
`else
   assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: scoreboard bench for sipo_rx. Stimulus drives one cycle at a
// time and pushes the expected post-edge outputs, computed by a bit-queue
// reference model, into a queue; a monitor pops and compares at each negedge.
module tb_sipo_rx;

   localparam int W = 4;
`ifdef SIPO_RX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         CLK = 1'b0;
   logic         RST_N, SIN, SIN_EN, FRAME, POUT_ACK;
   logic [W-1:0] POUT;
   logic         POUT_VALID, BUSY, ERR, OVF, PERR;

   sipo_rx #(.WIDTH(W)) dut (
      .CLK(CLK), .RST_N(RST_N), .SIN(SIN), .SIN_EN(SIN_EN), .FRAME(FRAME),
      .POUT_ACK(POUT_ACK), .POUT(POUT), .POUT_VALID(POUT_VALID), .BUSY(BUSY),
      .ERR(ERR), .OVF(OVF), .PERR(PERR)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [W-1:0] pout;
      logic         valid;
      logic         perr;
      logic         busy;
      logic         err;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Reference model state: bits received in the current frame plus outputs.
   bit           m_bits[$];
   logic [W-1:0] m_pout;
   logic         m_valid, m_perr, m_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle, advance the model, queue the expected outputs.
   task automatic step(input bit rst_n, input bit sin, input bit en,
                       input bit frame, input bit ack);
      exp_t e;
      bit   err  = 1'b0;
      bit   done = 1'b0;
      logic [W-1:0] w = '0;
      bit   p = 1'b0;
      RST_N = rst_n; SIN = sin; SIN_EN = en; FRAME = frame; POUT_ACK = ack;
      if (!rst_n) begin
         m_bits.delete();
         m_pout = '0; m_valid = 1'b0; m_perr = 1'b0; m_ovf = 1'b0;
      end else begin
         if (en) begin
            if (frame) begin
               err = (m_bits.size() > 0);
               m_bits.delete();
               m_bits.push_back(sin);
            end else if (m_bits.size() > 0) begin
               m_bits.push_back(sin);
            end
         end
         if (m_bits.size() == FL) begin
            for (int i = 0; i < W; i++) w = {w[W-2:0], m_bits[i]};
`ifdef SIPO_RX_PARITY_EN
            for (int i = 0; i < FL; i++) p = p ^ m_bits[i];
`endif
            done = 1'b1;
            m_bits.delete();
         end
         if (done) begin
            if (m_valid && !ack) m_ovf = 1'b1;
            m_pout = w; m_valid = 1'b1; m_perr = p;
         end else if (ack && m_valid) begin
            m_valid = 1'b0;
         end
      end
      e.pout = m_pout; e.valid = m_valid; e.perr = m_perr;
      e.busy = (m_bits.size() > 0); e.err = err; e.ovf = m_ovf;
      sb.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n, input bit ack);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, ack);
   endtask

   // Send a word MSB first with a correct parity bit when parity is built in.
   task automatic send_word(input logic [W-1:0] w, input bit ack_last);
      logic [W-1:0] v = w;
      for (int i = 0; i < W; i++)
         step(1, v[W-1-i], 1, (i == 0), (FL == W) && (i == W - 1) && ack_last);
`ifdef SIPO_RX_PARITY_EN
      step(1, ^v, 1, 0, ack_last);
`endif
   endtask

   // Monitor: pop one expectation per cycle and compare every output.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pout",  32'(POUT),       32'(e.pout));
            check("valid", 32'(POUT_VALID), 32'(e.valid));
            check("perr",  32'(PERR),       32'(e.perr));
            check("busy",  32'(BUSY),       32'(e.busy));
            check("err",   32'(ERR),        32'(e.err));
            check("ovf",   32'(OVF),        32'(e.ovf));
         end
      end
   end

   initial begin
      logic [W-1:0] v;
      // Reset
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 1);
      // Basic word 4'hB, then acknowledge
      send_word(4'hB, 0);
      idle(2, 0);
      idle(1, 1);
      idle(1, 1);
      // Same word with a 2-cycle gap between bits 2 and 3
      step(1, 1, 1, 1, 0);
      step(1, 0, 1, 0, 0);
      idle(2, 0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
`ifdef SIPO_RX_PARITY_EN
      step(1, 1, 1, 0, 0);
`endif
      idle(1, 1);
      // Bits without frame in IDLE are ignored
      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      idle(1, 0);
      // Back-to-back A then 5, no ack: overflow
      send_word(4'hA, 0);
      send_word(4'h5, 0);
      idle(2, 0);
      // Clear with reset, repeat acking the second completion
      step(0, 0, 0, 0, 0);
      send_word(4'hA, 0);
      send_word(4'h5, 1);
      idle(2, 0);
      idle(1, 1);
      // Resync: 1,1 then FRAME on a 1 followed by 0,0,1 -> 4'h9, one ERR
      step(1, 1, 1, 1, 0);
      step(1, 1, 1, 0, 0);
      send_word(4'h9, 0);
      idle(2, 1);
      // Reset mid-word, then fresh 4'h6
      step(1, 1, 1, 1, 0);
      step(1, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      send_word(4'h6, 0);
      idle(2, 1);
`ifdef SIPO_RX_PARITY_EN
      // Parity good then bad for 4'hB
      v = 4'hB;
      for (int i = 0; i < W; i++) step(1, v[W-1-i], 1, (i == 0), 0);
      step(1, 1, 1, 0, 0);
      idle(1, 1);
      for (int i = 0; i < W; i++) step(1, v[W-1-i], 1, (i == 0), 0);
      step(1, 0, 1, 0, 0);
      idle(1, 1);
      // Resync while waiting for the parity bit
      for (int i = 0; i < W; i++) step(1, v[W-1-i], 1, (i == 0), 0);
      step(1, 1, 1, 1, 0);
      idle(1, 0);
`endif
      // Randomized traffic
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) != 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) < 3));
      end
      idle(3, 0);
      repeat (2) @(negedge CLK);
      check("drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
